// File: rtl/mem_r_arbiter.sv
// Round-robin arbiter sharing one AXI read channel among N_REQ read masters.
// One burst outstanding at a time; AR and R phases are routed to the granted requester.
module mem_r_arbiter #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          s_arvalid,
  output logic [N_REQ-1:0]          s_arready,
  input  logic [N_REQ*ADDR_W-1:0]   s_araddr,
  input  logic [N_REQ*8-1:0]        s_arlen,
  input  logic [N_REQ*3-1:0]        s_arsize,
  input  logic [N_REQ*2-1:0]        s_arburst,
  output logic [N_REQ-1:0]          s_rvalid,
  input  logic [N_REQ-1:0]          s_rready,
  output logic [DATA_W-1:0]         s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      s_rlast,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [3:0]                m_arid,
  output logic [7:0]                m_arlen,
  output logic [2:0]                m_arsize,
  output logic [1:0]                m_arburst,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rlast,
  input  logic [3:0]                m_rid
);

  localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, AR, R} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] grant, grant_nxt;
  logic [GW-1:0] ptr, ptr_nxt;
  logic [GW-1:0] win;
  logic [GW:0]   scan_idx;
  logic          found;
  logic          unused_rid;

  assign unused_rid = ^m_rid;

  // First requesting index at or above ptr, wrapping at N_REQ
  always_comb begin
    win      = ptr;
    found    = 1'b0;
    scan_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan_idx = {1'b0, ptr} + (GW+1)'(i);
      if (scan_idx >= (GW+1)'(N_REQ)) scan_idx = scan_idx - (GW+1)'(N_REQ);
      if (!found && s_arvalid[GW'(scan_idx)]) begin
        found = 1'b1;
        win   = GW'(scan_idx);
      end
    end
  end

  // Address payload always follows the current grant; data returns are broadcast
  assign m_araddr  = s_araddr[int'(grant)*ADDR_W +: ADDR_W];
  assign m_arlen   = s_arlen[int'(grant)*8 +: 8];
  assign m_arsize  = s_arsize[int'(grant)*3 +: 3];
  assign m_arburst = s_arburst[int'(grant)*2 +: 2];
  assign m_arid    = 4'(grant);
  assign s_rdata   = m_rdata;
  assign s_rresp   = m_rresp;
  assign s_rlast   = m_rlast;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    s_arready = '0;
    s_rvalid  = '0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = win;
          state_nxt = AR;
        end
      end
      AR: begin
        m_arvalid        = s_arvalid[grant];
        s_arready[grant] = m_arready;
        if (s_arvalid[grant] && m_arready) state_nxt = R;
        else if (!s_arvalid[grant])        state_nxt = IDLE;
      end
      R: begin
        s_rvalid[grant] = m_rvalid;
        m_rready        = s_rready[grant];
        if (m_rvalid && s_rready[grant] && m_rlast) begin
          state_nxt = IDLE;
          ptr_nxt   = (grant == GW'(N_REQ-1)) ? '0 : grant + GW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_r_arbiter.sv
// Self-checking bench for mem_r_arbiter: directed bursts, an arbitration table,
// backpressure/withdrawal/reset corner cases, and randomized transactions vs a queue-level model.
module tb_mem_r_arbiter;
  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [N*AW-1:0] s_araddr;
  logic [N*8-1:0]  s_arlen;
  logic [N*3-1:0]  s_arsize;
  logic [N*2-1:0]  s_arburst;
  logic [DW-1:0]   s_rdata, m_rdata;
  logic [1:0]      s_rresp, m_rresp;
  logic            s_rlast, m_rlast;
  logic            m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AW-1:0]   m_araddr;
  logic [3:0]      m_arid, m_rid;
  logic [7:0]      m_arlen;
  logic [2:0]      m_arsize;
  logic [1:0]      m_arburst;

  logic [AW-1:0] req_addr  [N];
  logic [7:0]    req_len   [N];
  logic [2:0]    req_size  [N];
  logic [1:0]    req_burst [N];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      s_araddr[i*AW +: AW] = req_addr[i];
      s_arlen[i*8 +: 8]    = req_len[i];
      s_arsize[i*3 +: 3]   = req_size[i];
      s_arburst[i*2 +: 2]  = req_burst[i];
    end
  end

  mem_r_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rid(m_rid)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Round-robin model: first requesting index scanning up from p, modulo N
  function automatic int pick(input logic [N-1:0] mask, input int p);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (p + i) % N;
      if (mask[j]) return j;
    end
    return -1;
  endfunction

  task automatic reset_dut();
    reset = 1'b1; s_arvalid = '0; m_arready = 1'b0; m_rvalid = 1'b0;
    m_rlast = 1'b0; s_rready = '0;
    step(); step();
    settle();
    check("rst.m_arvalid", m_arvalid, 0);
    check("rst.m_rready", m_rready, 0);
    check("rst.s_arready", s_arready, 0);
    check("rst.s_rvalid", s_rvalid, 0);
    check("rst.m_araddr", m_araddr, req_addr[0]);
    reset = 1'b0;
  endtask

  // Starts in IDLE; one request burst of nbeats with immediate AR accept and no R stalls
  task automatic run_burst(input logic [N-1:0] mask, input int exp_w, input int nbeats,
                           input string tag);
    logic [DW-1:0] d;
    s_arvalid = mask; m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = '1;
    settle();
    check({tag, ".idle_arvalid"}, m_arvalid, 0);
    step();
    settle();
    check({tag, ".arvalid"}, m_arvalid, 1);
    check({tag, ".arid"}, m_arid, exp_w);
    check({tag, ".araddr"}, m_araddr, req_addr[exp_w]);
    check({tag, ".arlen"}, m_arlen, req_len[exp_w]);
    check({tag, ".arready_wait"}, s_arready, 0);
    m_arready = 1'b1;
    settle();
    check({tag, ".arready"}, s_arready, 64'(1) << exp_w);
    step();
    s_arvalid[exp_w] = 1'b0; m_arready = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      d = $urandom;
      m_rvalid = 1'b1; m_rdata = d; m_rresp = 2'(b); m_rlast = (b == nbeats - 1);
      settle();
      check({tag, ".rvalid"}, s_rvalid, 64'(1) << exp_w);
      check({tag, ".rdata"}, s_rdata, d);
      check({tag, ".rlast"}, s_rlast, (b == nbeats - 1));
      step();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    settle();
    check({tag, ".end_rready"}, m_rready, 0);
    check({tag, ".end_rvalid"}, s_rvalid, 0);
  endtask

  typedef struct {
    logic [N-1:0] mask;
    int           exp_w;
    int           beats;
  } arb_vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arb_vec_t      tbl [10];
    logic [DW-1:0] bp_data [4];
    int            mptr;

    reset = 1'b1; s_arvalid = '0; s_rready = '0; m_arready = 1'b0;
    m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rid = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i] = 32'h1000_0000 + 32'(i) * 32'h100;
      req_len[i] = 8'(i); req_size[i] = 3'd2; req_burst[i] = 2'd1;
    end

    // Single ICache burst, then pointer sits at 1
    req_addr[0] = 32'h8000_0010; req_len[0] = 8'd3;
    reset_dut();
    run_burst(3'b001, 0, 4, "icache");
    run_burst(3'b011, 1, 1, "icache_ptr");

    // Simultaneous requests rotate 0,1,2,0
    reset_dut();
    for (int k = 0; k < 4; k++) run_burst(3'b111, k % 3, 1, "simul");

    // Arbitration table from reset (pointer starts at 0)
    tbl[0] = '{3'b001, 0, 1}; tbl[1] = '{3'b101, 2, 2}; tbl[2] = '{3'b011, 0, 1};
    tbl[3] = '{3'b011, 1, 3}; tbl[4] = '{3'b011, 0, 1}; tbl[5] = '{3'b100, 2, 1};
    tbl[6] = '{3'b110, 1, 2}; tbl[7] = '{3'b111, 2, 1}; tbl[8] = '{3'b111, 0, 1};
    tbl[9] = '{3'b010, 1, 1};
    reset_dut();
    for (int i = 0; i < 10; i++) run_burst(tbl[i].mask, tbl[i].exp_w, tbl[i].beats, "table");

    // Backpressure on AR then alternating s_rready[1]
    reset_dut();
    for (int i = 0; i < 4; i++) bp_data[i] = 32'hB000_0000 + 32'(i);
    s_arvalid = 3'b010;
    step();
    for (int k = 0; k < 5; k++) begin
      settle();
      check("bp.arvalid", m_arvalid, 1);
      check("bp.arready_low", s_arready, 0);
      step();
    end
    m_arready = 1'b1;
    settle();
    check("bp.arready", s_arready, 3'b010);
    step();
    s_arvalid = '0; m_arready = 1'b0;
    begin
      int b, cyc;
      logic rr;
      b = 0; cyc = 0; rr = 1'b0;
      while (b < 4 && cyc < 20) begin
        s_rready = rr ? 3'b111 : 3'b101;
        m_rvalid = 1'b1; m_rdata = bp_data[b]; m_rlast = (b == 3);
        settle();
        check("bp.rready_track", m_rready, rr);
        check("bp.rvalid", s_rvalid, 3'b010);
        check("bp.rdata", s_rdata, bp_data[b]);
        if (rr) b++;
        step();
        rr = ~rr; cyc++;
      end
      check("bp.beats", b, 4);
    end
    m_rvalid = 1'b1; m_rlast = 1'b0; s_rready = '1;
    settle();
    check("bp.stray_rready", m_rready, 0);
    check("bp.stray_rvalid", s_rvalid, 0);
    m_rvalid = 1'b0;

    // Withdrawal: requester 2 wins then drops its request
    reset_dut();
    run_burst(3'b001, 0, 1, "wd_pre");
    s_arvalid = 3'b100; m_arready = 1'b0;
    step();
    settle();
    check("wd.arid", m_arid, 2);
    check("wd.arvalid", m_arvalid, 1);
    s_arvalid = '0;
    settle();
    check("wd.arvalid_drop", m_arvalid, 0);
    check("wd.arready", s_arready, 0);
    step();
    m_rvalid = 1'b1; m_arready = 1'b1;
    settle();
    check("wd.idle_arvalid", m_arvalid, 0);
    check("wd.idle_rready", m_rready, 0);
    check("wd.idle_rvalid", s_rvalid, 0);
    m_rvalid = 1'b0; m_arready = 1'b0;
    run_burst(3'b111, 1, 1, "wd_ptr");

    // Reset asserted on beat 2 of a 4-beat burst
    reset_dut();
    s_arvalid = 3'b001; s_rready = '1;
    step();
    m_arready = 1'b1;
    step();
    s_arvalid = '0; m_arready = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b0;
    step();
    reset = 1'b1;
    settle();
    check("rmid.beat2", s_rvalid, 3'b001);
    step();
    reset = 1'b0; s_arvalid = 3'b001;
    settle();
    check("rmid.arvalid", m_arvalid, 0);
    check("rmid.rready", m_rready, 0);
    check("rmid.arready", s_arready, 0);
    check("rmid.rvalid", s_rvalid, 0);
    m_rvalid = 1'b0;
    step();
    settle();
    check("rmid.regrant", m_arvalid, 1);
    check("rmid.regrant_id", m_arid, 0);

    // Randomized transactions against the round-robin model
    reset_dut();
    mptr = 0;
    for (int t = 0; t < 150; t++) begin
      logic [N-1:0]  mask;
      logic [DW-1:0] d;
      logic [1:0]    rsp;
      int            w, dly, beats, cnt, cyc;
      mask = 3'($urandom_range(1, 7));
      for (int i = 0; i < N; i++) begin
        req_addr[i] = $urandom; req_len[i] = 8'($urandom_range(0, 3));
        req_size[i] = 3'($urandom); req_burst[i] = 2'($urandom);
      end
      s_arvalid = mask; m_arready = 1'b0; m_rvalid = 1'($urandom); m_rlast = 1'b1;
      settle();
      check("rnd.idle_arvalid", m_arvalid, 0);
      check("rnd.idle_rready", m_rready, 0);
      check("rnd.idle_rvalid", s_rvalid, 0);
      m_rvalid = 1'b0;
      step();
      w = pick(mask, mptr);
      dly = $urandom_range(0, 3);
      for (int k = 0; k <= dly; k++) begin
        m_arready = (k == dly);
        settle();
        check("rnd.arvalid", m_arvalid, 1);
        check("rnd.arid", m_arid, w);
        check("rnd.araddr", m_araddr, req_addr[w]);
        check("rnd.arlen", m_arlen, req_len[w]);
        check("rnd.arsize", m_arsize, req_size[w]);
        check("rnd.arburst", m_arburst, req_burst[w]);
        check("rnd.arready", s_arready, (k == dly) ? (64'(1) << w) : 64'(0));
        check("rnd.ar_rready", m_rready, 0);
        step();
      end
      m_arready = 1'b0;
      beats = int'(req_len[w]) + 1; cnt = 0; cyc = 0;
      while (cnt < beats && cyc < 64) begin
        d = $urandom; rsp = 2'($urandom);
        m_rvalid = 1'($urandom); s_rready = 3'($urandom);
        m_rdata = d; m_rresp = rsp; m_rlast = (cnt == beats - 1);
        s_arvalid = 3'($urandom) & ~(3'(1) << w);
        settle();
        check("rnd.rvalid", s_rvalid, m_rvalid ? (64'(1) << w) : 64'(0));
        check("rnd.rready", m_rready, s_rready[w]);
        check("rnd.rdata", s_rdata, d);
        check("rnd.rresp", s_rresp, rsp);
        check("rnd.r_arvalid", m_arvalid, 0);
        check("rnd.r_arready", s_arready, 0);
        if (m_rvalid && s_rready[w]) cnt++;
        step();
        cyc++;
      end
      m_rvalid = 1'b0;
      check("rnd.beats_done", cnt, beats);
      if (cnt != beats) begin
        reset_dut();
        mptr = 0;
      end else begin
        mptr = (w + 1) % N;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_r_arbiter.md
# mem_r_arbiter

Shares the single memory-side AXI read channel between up to `N_REQ` read masters: instruction-cache refill, data-side loads and the page-table walker. It arbitrates one burst at a time and routes the address phase and all data beats to the winning requester. It sits between the core's read masters and the memory/bus bridge.

## Interface
Parameters:
- `N_REQ`, 3: number of requesters. Index 0 is the ICache, 1 the LSU, 2 the PTW.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `s_arvalid`  in  N_REQ  per-requester AR valid.
- `s_arready`  out  N_REQ  per-requester AR ready.
- `s_araddr`  in  N_REQ*ADDR_W  packed; slice i belongs to requester i.
- `s_arlen`  in  N_REQ*8  packed burst lengths.
- `s_arsize`  in  N_REQ*3  packed.
- `s_arburst`  in  N_REQ*2  packed.
- `s_rvalid`  out  N_REQ  per-requester R valid.
- `s_rready`  in  N_REQ  per-requester R ready.
- `s_rdata`  out  DATA_W  broadcast to all requesters.
- `s_rresp`  out  2  broadcast.
- `s_rlast`  out  1  broadcast.
- `m_arvalid`, `m_arready`, `m_araddr`, `m_arid[3:0]`, `m_arlen`, `m_arsize`, `m_arburst`  AXI AR, master side.
- `m_rvalid`, `m_rready`, `m_rdata`, `m_rresp`, `m_rlast`, `m_rid`  AXI R, master side. `m_rid` is ignored.

## Operation
- Only one transaction is outstanding. Registered state: `state`, `grant` (log2 N_REQ bits) and round-robin pointer `ptr`.
- **IDLE**:
  - If any `s_arvalid` is set, the winner is the first set bit scanning upward from `ptr` with wrap-around.
  - `grant` takes the winner and the state moves to AR.
  - If no `s_arvalid` is set, the block stays in IDLE.
- **AR**:
  - `m_arvalid = s_arvalid[grant]`.
  - `m_araddr`, `m_arlen`, `m_arsize` and `m_arburst` are muxed from slice `grant`.
  - `m_arid = grant`, zero-extended.
  - `s_arready[grant] = m_arready`; all other `s_arready` bits are 0.
  - If `m_arvalid & m_arready`, the state moves to R.
  - If `s_arvalid[grant]` is 0, the requester has withdrawn. The state returns to IDLE and `ptr` is unchanged. No downstream handshake occurs because `m_arvalid` follows the requester combinationally.
- **R**:
  - `s_rvalid[grant] = m_rvalid`; all other bits are 0.
  - `m_rready = s_rready[grant]`.
  - Data, resp and last are passed through unmodified. Error responses are forwarded, not handled.
  - If `m_rvalid & m_rready & m_rlast`, the state moves to IDLE and `ptr` takes `grant+1`, wrapping at `N_REQ`.
- Outside R: `m_rready = 0` and all `s_rvalid` bits are 0. A stray `m_rvalid` is not accepted.
- Outside AR: `m_arvalid = 0` and all `s_arready` bits are 0.
- Requests arriving while the block is in AR or R wait. They are not queued; the requester holds `s_arvalid`.

## Timing
- Reset:
  - `state = IDLE`, `grant = 0`, `ptr = 0`.
  - All outputs are 0: `m_arvalid`, `m_rready`, `s_arready`, `s_rvalid`.
  - Muxed data outputs reflect slice 0.
- Arbitration latency is 1 cycle. A request seen in IDLE at edge k drives `m_arvalid` in cycle k+1.
- The R→IDLE transition is also 1 cycle. The earliest next `m_arvalid` is 2 cycles after the `rlast` beat.
- A burst of L+1 beats occupies AR for at least 1 cycle plus R for at least L+1 cycles. Each beat costs exactly one `m_rvalid & m_rready` cycle; there is no added bubble.
- Simultaneous requests in IDLE: a single winner is taken per the pointer scan. Losers are never starved; each waits at most `N_REQ-1` bursts.
- Reset mid-burst: the block returns to IDLE immediately. Downstream is reset on the same `reset`. Partial beats are lost, and requesters must also reset.

## Test plan
- **Single ICache burst.** Reset, then `s_arvalid=3'b001`, `araddr=0x8000_0010`, `arlen=3`. Required:
  - `m_arvalid` in cycle 1 with `m_arid=0` and `m_araddr=0x8000_0010`.
  - Four beats routed only to `s_rvalid[0]`.
  - IDLE after `rlast`.
  - `ptr=1`.
- **Simultaneous requests.** All three requesters hold `s_arvalid` and each issues a 1-beat burst. Required:
  - Grant order 0, 1, 2, 0.
  - `m_arid` sequence 0, 1, 2, 0.
- **Backpressure.** Hold `m_arready=0` for 5 cycles, then toggle `s_rready[1]` on alternate cycles during a 4-beat burst from requester 1. Required:
  - `s_arready[1]` rises only with `m_arready`.
  - Exactly 4 beats delivered with data order preserved.
  - `m_rready` tracks `s_rready[1]`.
- **Withdrawal.** Requester 2 wins, then drops `s_arvalid` in AR while `m_arready=0`. Required:
  - Return to IDLE.
  - `ptr` unchanged.
  - No AR handshake downstream.
- **Reset mid-R.** Assert `reset` on beat 2 of 4. Required:
  - The next cycle shows all outputs 0 and IDLE.
  - A fresh request from requester 0 is granted within 1 cycle.
